// File: rtl/i2c_tx_sched.sv
// Arbitrates two requesters onto one I2C transmitter and tracks START/STOP/gap on the bus.
// Grant/launch one cycle after a request is seen in IDLE; done one cycle after STOP or timeout.
// Requesters wait by holding req_i; optional round-robin tie-break under I2C_TX_SCHED_RR_EN.
module i2c_tx_sched #(
    parameter int START_TMO = 255,
    parameter int XFER_TMO  = 12000,
    parameter int GAP_CYC   = 60
) (
    input  logic        clk_i,
    input  logic        _rst_i,
    input  logic [1:0]  req_i,
    input  logic [23:0] cmd0_i,
    input  logic [23:0] cmd1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        start_tx_o,
    output logic [23:0] datatx_o,
    input  logic        bus_scl_i,
    input  logic        bus_sda_i
);

    localparam int TMAX_A = (START_TMO > XFER_TMO) ? START_TMO : XFER_TMO;
    localparam int TMAX   = (TMAX_A > GAP_CYC) ? TMAX_A : GAP_CYC;
    localparam int TW     = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, XFER, GAP} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt, timer_inc;
    logic          load, fin, fin_err, pick, win;
    logic          scl_q1, scl_s, scl_d, sda_q1, sda_s, sda_d;
    logic          start_det, stop_det;

    // Third flop keeps the previous synchronized sample for edge detection.
    always_ff @(posedge clk_i or negedge _rst_i) begin
        if (!_rst_i) begin
            scl_q1 <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
            sda_q1 <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_q1 <= bus_scl_i; scl_s <= scl_q1; scl_d <= scl_s;
            sda_q1 <= bus_sda_i; sda_s <= sda_q1; sda_d <= sda_s;
        end
    end

    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

`ifdef I2C_TX_SCHED_RR_EN
    logic rr_last;

    always_comb begin
        pick = ~req_i[0];
        if (req_i == 2'b11) pick = ~rr_last;
    end

    always_ff @(posedge clk_i or negedge _rst_i) begin
        if (!_rst_i)   rr_last <= 1'b1;
        else if (load) rr_last <= pick;
    end
`else
    assign pick = ~req_i[0];
`endif

    assign timer_inc = (timer == TW'(TMAX)) ? timer : timer + TW'(1);
    assign busy_o    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer_inc;
        load      = 1'b0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (req_i != 2'b00) begin
                    load      = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_nxt = '0;
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (start_det) begin
                    timer_nxt = '0;
                    state_nxt = XFER;
                end else if (timer == TW'(START_TMO - 1)) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = GAP;
                end
            end
            XFER: begin
                if (stop_det) begin
                    fin       = 1'b1;
                    timer_nxt = '0;
                    state_nxt = GAP;
                end else if (timer == TW'(XFER_TMO - 1)) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                // Only an uninterrupted run of bus-free cycles counts.
                if (scl_s && sda_s) begin
                    if (timer == TW'(GAP_CYC - 1)) begin
                        timer_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = '0;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge _rst_i) begin
        if (!_rst_i) begin
            state      <= IDLE;
            timer      <= '0;
            win        <= 1'b0;
            gnt_o      <= 2'b00;
            done_o     <= 2'b00;
            err_o      <= 1'b0;
            start_tx_o <= 1'b0;
            datatx_o   <= '0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            start_tx_o <= load;
            gnt_o      <= load ? (pick ? 2'b10 : 2'b01) : 2'b00;
            done_o     <= fin ? (win ? 2'b10 : 2'b01) : 2'b00;
            err_o      <= fin & fin_err;
            if (load) begin
                win      <= pick;
                datatx_o <= pick ? cmd1_i : cmd0_i;
            end
        end
    end

endmodule

// File: tb/tb_i2c_tx_sched.sv
// Directed bench for i2c_tx_sched with default timing parameters.
module tb_i2c_tx_sched;

    logic        clk_i = 1'b0;
    logic        _rst_i;
    logic [1:0]  req_i;
    logic [23:0] cmd0_i, cmd1_i;
    logic [1:0]  gnt_o, done_o;
    logic        err_o, busy_o, start_tx_o;
    logic [23:0] datatx_o;
    logic        bus_scl_i, bus_sda_i;

    int checks = 0;
    int failures = 0;
    int n;

`ifdef I2C_TX_SCHED_RR_EN
    localparam logic [1:0]  SECOND_GNT = 2'b10;
    localparam logic [23:0] SECOND_CMD = 24'h222222;
`else
    localparam logic [1:0]  SECOND_GNT = 2'b01;
    localparam logic [23:0] SECOND_CMD = 24'h111111;
`endif

    i2c_tx_sched dut (
        .clk_i      (clk_i),
        ._rst_i     (_rst_i),
        .req_i      (req_i),
        .cmd0_i     (cmd0_i),
        .cmd1_i     (cmd1_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .start_tx_o (start_tx_o),
        .datatx_o   (datatx_o),
        .bus_scl_i  (bus_scl_i),
        .bus_sda_i  (bus_sda_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tickn(input int k);
        repeat (k) tick();
    endtask

    task automatic wait_done(input int max, output int cnt);
        cnt = 0;
        while (done_o == 2'b00 && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_gnt(input int max, output int cnt);
        cnt = 0;
        while (gnt_o == 2'b00 && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_idle(input int max, output int cnt);
        cnt = 0;
        while (busy_o !== 1'b0 && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        _rst_i = 1'b0; req_i = 2'b00; cmd0_i = '0; cmd1_i = '0;
        bus_scl_i = 1'b1; bus_sda_i = 1'b1;
        tickn(3);
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_done", done_o, 2'b00);
        chk("rst_err", err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_start", start_tx_o, 1'b0);
        chk("rst_datatx", datatx_o, 24'h0);
        _rst_i = 1'b1;
        tickn(2);
        chk("idle_busy", busy_o, 1'b0);

        // Single request, START at +20, STOP at +4000.
        cmd0_i = 24'hA01055; req_i = 2'b01;
        tick();
        chk("a_gnt", gnt_o, 2'b01);
        chk("a_start", start_tx_o, 1'b1);
        chk("a_datatx", datatx_o, 24'hA01055);
        req_i = 2'b00;
        tick();
        chk("a_start_pulse", start_tx_o, 1'b0);
        chk("a_gnt_pulse", gnt_o, 2'b00);
        tickn(18); bus_sda_i = 1'b0;
        tickn(10); bus_scl_i = 1'b0;
        tickn(3961); bus_scl_i = 1'b1;
        tickn(10);
        chk("a_busy_xfer", busy_o, 1'b1);
        chk("a_datatx_hold", datatx_o, 24'hA01055);
        bus_sda_i = 1'b1;
        wait_done(20, n);
        chk("a_done_lat", n, 3);
        chk("a_done", done_o, 2'b01);
        chk("a_err", err_o, 1'b0);
        tick();
        chk("a_done_pulse", done_o, 2'b00);
        wait_idle(200, n);
        chk("a_gap_len", n, 59);

        // Repeated START inside XFER, cmd1 changed after grant.
        cmd1_i = 24'h123456; req_i = 2'b10;
        tick();
        chk("r_gnt", gnt_o, 2'b10);
        chk("r_datatx", datatx_o, 24'h123456);
        req_i = 2'b00; cmd1_i = 24'hFFFFFF;
        bus_sda_i = 1'b0; tickn(5);
        bus_scl_i = 1'b0; tickn(5);
        bus_sda_i = 1'b1; tickn(5);
        bus_scl_i = 1'b1; tickn(5);
        bus_sda_i = 1'b0; tickn(5);
        chk("r_no_done_rs", done_o, 2'b00);
        chk("r_datatx_hold", datatx_o, 24'h123456);
        bus_scl_i = 1'b0; tickn(5);
        bus_scl_i = 1'b1; tickn(5);
        bus_sda_i = 1'b1;
        wait_done(20, n);
        chk("r_done_lat", n, 3);
        chk("r_done", done_o, 2'b10);
        chk("r_err", err_o, 1'b0);
        tick();
        chk("r_done_pulse", done_o, 2'b00);
        wait_idle(200, n);
        chk("r_gap_len", n, 59);

        // Both requesters held for three START-timeout transactions.
        cmd0_i = 24'h111111; cmd1_i = 24'h222222; req_i = 2'b11;
        tick();
        chk("t_gnt1", gnt_o, 2'b01);
        chk("t_cmd1", datatx_o, 24'h111111);
        tick();
        wait_gnt(400, n);
        chk("t_regrant_lat", n, 316);
        chk("t_gnt2", gnt_o, SECOND_GNT);
        chk("t_cmd2", datatx_o, SECOND_CMD);
        tick();
        wait_gnt(400, n);
        chk("t_gnt3", gnt_o, 2'b01);
        chk("t_cmd3", datatx_o, 24'h111111);
        req_i = 2'b00;
        wait_done(400, n);
        chk("t_done3", done_o, 2'b01);
        wait_idle(100, n);

        // No START ever appears.
        cmd0_i = 24'hABCDEF; req_i = 2'b01;
        tick();
        chk("s_gnt", gnt_o, 2'b01);
        req_i = 2'b00;
        wait_done(400, n);
        chk("s_tmo_lat", n, 256);
        chk("s_done", done_o, 2'b01);
        chk("s_err", err_o, 1'b1);
        wait_idle(100, n);
        chk("s_gap_len", n, 60);

        // SDA stuck low after START.
        cmd1_i = 24'h0F0F0F; req_i = 2'b10;
        tick();
        chk("x_gnt", gnt_o, 2'b10);
        req_i = 2'b00; bus_sda_i = 1'b0;
        wait_done(13000, n);
        chk("x_tmo_lat", n, 12003);
        chk("x_done", done_o, 2'b10);
        chk("x_err", err_o, 1'b1);
        tickn(100);
        chk("x_gap_hold", busy_o, 1'b1);
        bus_sda_i = 1'b1;
        wait_idle(200, n);
        chk("x_gap_len", n, 62);

        // Reset in the middle of XFER.
        cmd0_i = 24'h0A0B0C; req_i = 2'b01;
        tick();
        req_i = 2'b00; bus_sda_i = 1'b0;
        tickn(8);
        chk("q_busy", busy_o, 1'b1);
        _rst_i = 1'b0;
        #1;
        chk("q_gnt", gnt_o, 2'b00);
        chk("q_done", done_o, 2'b00);
        chk("q_busy0", busy_o, 1'b0);
        chk("q_datatx", datatx_o, 24'h0);
        bus_sda_i = 1'b1;
        tickn(4);
        chk("q_done_rst", done_o, 2'b00);
        _rst_i = 1'b1;
        cmd1_i = 24'h00BEEF; req_i = 2'b10;
        tick();
        chk("q_regnt", gnt_o, 2'b10);
        chk("q_redata", datatx_o, 24'h00BEEF);
        req_i = 2'b00;
        wait_done(400, n);
        chk("q_tmo_lat", n, 256);
        chk("q_redone", done_o, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_tx_sched.md
I2C_TX_SCHED -- requirements
Module: i2c_tx_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter START_TMO, default 255: clock cycles allowed from launch to a detected START.
REQ-002 The block SHALL have parameter XFER_TMO, default 12000: clock cycles allowed from START to a detected STOP.
REQ-003 The block SHALL have parameter GAP_CYC, default 60: bus-free cycles required after a transaction before the next launch.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have these ports, clock and reset first:
- clk_i  in  1  single clock, rising edge.
- _rst_i  in  1  asynchronous, active-low reset.
- req_i  in  2  request per requester; bit k asserted while cmdk_i is valid.
- cmd0_i  in  24  requester 0 transaction {slave_addr, reg_addr, data}.
- cmd1_i  in  24  requester 1 transaction, same layout.
- gnt_o  out  2  one-cycle grant pulse per requester.
- done_o  out  2  one-cycle completion pulse per requester.
- err_o  out  1  timeout status; valid only while any done_o bit is high.
- busy_o  out  1  high in every state except IDLE.
- start_tx_o  out  1  launch pulse to the transmitter.
- datatx_o  out  24  transaction word to the transmitter.
- bus_scl_i  in  1  resolved SCL line, 1 when released.
- bus_sda_i  in  1  resolved SDA line, 1 when released.

Function
REQ-005 bus_scl_i and bus_sda_i SHALL pass through 2-flop synchronizers; START and STOP detection SHALL use only the synchronized values.
REQ-006 START SHALL be detected as synchronized SDA going 1->0 while synchronized SCL is 1 in both samples; STOP SHALL be detected as synchronized SDA going 0->1 while synchronized SCL is 1 in both samples.
REQ-007 The state machine SHALL have exactly five states: IDLE, LAUNCH, WAIT_START, XFER, GAP.
REQ-008 IDLE: if req_i != 0, the block SHALL select a winner, load datatx_o with the winner's cmd, record the winner, and go to LAUNCH on the next edge; otherwise it SHALL stay in IDLE.
REQ-009 LAUNCH: for exactly one cycle, start_tx_o SHALL be 1 and gnt_o[winner] SHALL be 1; the block SHALL then go to WAIT_START with the timer cleared.
REQ-010 Latency from req_i sampled high in IDLE to start_tx_o/gnt_o high SHALL be exactly 1 cycle.
REQ-011 datatx_o SHALL hold its value from the load until the next IDLE load; it SHALL NOT change during WAIT_START, XFER or GAP.
REQ-012 WAIT_START: a detected START SHALL move the block to XFER with the timer cleared. If the timer reaches START_TMO-1 first, the block SHALL pulse done_o[winner] with err_o=1 and go to GAP.
REQ-013 XFER: a detected STOP SHALL pulse done_o[winner] with err_o=0 and move to GAP. If the timer reaches XFER_TMO-1 first, it SHALL pulse done_o[winner] with err_o=1 and go to GAP. A repeated START in XFER SHALL be ignored.
REQ-014 A STOP detected in WAIT_START SHALL be ignored.
REQ-015 GAP: the timer SHALL count only cycles in which synchronized SCL=1 and SDA=1, and SHALL clear whenever either line is 0. At count GAP_CYC-1 the block SHALL go to IDLE.
REQ-016 Requesters SHALL hold cmdk_i stable while req_i[k]=1. The block SHALL capture cmd only at the IDLE load.
REQ-017 req_i[k] deasserted before the load SHALL produce no grant.
REQ-018 req_i[k] still high after done_o[k] SHALL be treated as a new request.
REQ-019 At most one gnt_o bit and at most one done_o bit SHALL be high in any cycle. Every gnt_o pulse SHALL be followed by exactly one done_o pulse to the same requester.
REQ-020 The timer SHALL be wide enough for max(START_TMO, XFER_TMO, GAP_CYC) and SHALL saturate, never wrap.

Reset
REQ-021 While _rst_i=0, the block SHALL force state to IDLE and clear all of: gnt_o, done_o, err_o, busy_o, start_tx_o, datatx_o, the timer, the synchronizers (set to 1), the winner record, and the round-robin pointer (set to 1).
REQ-022 Reset asserted mid-transaction SHALL abort the transaction with no done_o pulse.
REQ-023 After reset release, the block SHALL allow a launch no earlier than the first IDLE evaluation.

Configuration
REQ-024 With macro I2C_TX_SCHED_RR_EN defined, when both req_i bits are high in IDLE the block SHALL grant the requester not granted last, then update the pointer to the winner.
REQ-025 Without I2C_TX_SCHED_RR_EN, requester 0 SHALL always win a tie and no pointer register SHALL exist. Single-request behaviour SHALL be identical in both builds.

Verification
REQ-026 Scenario: req_i=01, cmd0=0xA0_10_55; bus model drives START 20 cycles and STOP 4000 cycles after launch -> gnt_o=01 one cycle after req, start_tx_o pulse of 1 cycle, datatx_o=0xA01055, done_o=01 with err_o=0.
REQ-027 Scenario: req_i=11 held for 3 transactions, RR build -> grant order 01,10,01. Non-RR build -> 01,01,01.
REQ-028 Scenario: no START ever appears -> done_o pulse with err_o=1 exactly START_TMO cycles after WAIT_START entry, then GAP, then IDLE.
REQ-029 Scenario: SDA held low after START (no STOP) -> err_o=1 done at XFER_TMO. GAP does not exit while SDA=0.
REQ-030 Scenario: _rst_i pulsed low during XFER -> all outputs 0 asynchronously, no done_o. A new request after release is granted normally.
REQ-031 Scenario: repeated START mid-XFER followed by STOP -> single done_o with err_o=0. cmd1_i changed during XFER -> datatx_o unchanged.
